// File: rtl/cnt_cmp_seq_ctrl.sv
// Run sequencer for the nibble-counter / one-hot compare datapath: drives P_0/C_OUT, records first match.
// Optional HIT_TOTAL_EN adds hit_tot_o, a saturating count of matching RUN cycles.
//
// state  | meaning
// S_IDLE | waiting for start_i, p_0_o low
// S_RUN  | p_0_o high, z_i sampled every cycle
// S_DONE | one-cycle done_o pulse, then back to S_IDLE
module cnt_cmp_seq_ctrl #(
    parameter int CW = 16,
    parameter int NC = 17
) (
    input  logic          ck_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          stop_on_hit_i,
    input  logic [CW-1:0] max_cyc_i,
    input  logic [NC-1:0] cfg_c_i,
    input  logic          z_i,
    output logic          p_0_o,
    output logic [NC-1:0] c_out_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          hit_o,
    output logic [CW-1:0] hit_cnt_o,
    output logic          aborted_o
`ifdef HIT_TOTAL_EN
    ,
    output logic [CW-1:0] hit_tot_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic          p_0_q;
    logic [NC-1:0] c_out_q;
    logic          busy_q;
    logic          done_q;
    logic          hit_q;
    logic [CW-1:0] hit_cnt_q;
    logic          aborted_q;
    logic [CW-1:0] len_q;
    logic          soh_q;
    logic [CW-1:0] cyc_q;
    logic [CW-1:0] cyc_d;
    logic          run_end_d;
`ifdef HIT_TOTAL_EN
    logic [CW-1:0] hit_tot_q;
`endif

    // cyc_q never exceeds len_q-1 inside RUN, so the increment cannot wrap.
    always_comb begin
        cyc_d     = cyc_q + 1'b1;
        run_end_d = (cyc_q == len_q - 1'b1) || (z_i && soh_q) || abort_i;
    end

    always_ff @(posedge ck_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            p_0_q     <= 1'b0;
            c_out_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
            aborted_q <= 1'b0;
            len_q     <= '0;
            soh_q     <= 1'b0;
            cyc_q     <= '0;
`ifdef HIT_TOTAL_EN
            hit_tot_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    p_0_q  <= 1'b0;
                    busy_q <= 1'b0;
                    if (start_i) begin
                        c_out_q   <= cfg_c_i;
                        len_q     <= max_cyc_i;
                        soh_q     <= stop_on_hit_i;
                        hit_q     <= 1'b0;
                        hit_cnt_q <= '0;
                        aborted_q <= 1'b0;
                        cyc_q     <= '0;
                        busy_q    <= 1'b1;
`ifdef HIT_TOTAL_EN
                        hit_tot_q <= '0;
`endif
                        if (max_cyc_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            p_0_q   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (z_i && !hit_q) begin
                        hit_q     <= 1'b1;
                        hit_cnt_q <= cyc_q;
                    end
`ifdef HIT_TOTAL_EN
                    if (z_i && (hit_tot_q != '1)) begin
                        hit_tot_q <= hit_tot_q + 1'b1;
                    end
`endif
                    cyc_q <= cyc_d;
                    if (abort_i) begin
                        aborted_q <= 1'b1;
                    end
                    if (run_end_d) begin
                        state_q <= S_DONE;
                        p_0_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    p_0_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    p_0_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign p_0_o     = p_0_q;
    assign c_out_o   = c_out_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign hit_o     = hit_q;
    assign hit_cnt_o = hit_cnt_q;
    assign aborted_o = aborted_q;
`ifdef HIT_TOTAL_EN
    assign hit_tot_o = hit_tot_q;
`endif

endmodule

// File: tb/tb_cnt_cmp_seq_ctrl.sv
// Directed bench for cnt_cmp_seq_ctrl; expected values are hand-derived per scenario.
module tb_cnt_cmp_seq_ctrl;

    logic        ck = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        soh = 1'b0;
    logic [15:0] max_cyc = '0;
    logic [16:0] cfg_c = '0;
    logic        z = 1'b0;
    logic        p_0;
    logic [16:0] c_out;
    logic        busy;
    logic        done;
    logic        hit;
    logic [15:0] hit_cnt;
    logic        aborted;
`ifdef HIT_TOTAL_EN
    logic [15:0] hit_tot;
`endif

    int total = 0;
    int bad = 0;

    cnt_cmp_seq_ctrl #(.CW(16), .NC(17)) dut (
        .ck_i          (ck),
        .rst_i         (rst),
        .start_i       (start),
        .abort_i       (abort),
        .stop_on_hit_i (soh),
        .max_cyc_i     (max_cyc),
        .cfg_c_i       (cfg_c),
        .z_i           (z),
        .p_0_o         (p_0),
        .c_out_o       (c_out),
        .busy_o        (busy),
        .done_o        (done),
        .hit_o         (hit),
        .hit_cnt_o     (hit_cnt),
        .aborted_o     (aborted)
`ifdef HIT_TOTAL_EN
        ,
        .hit_tot_o     (hit_tot)
`endif
    );

    always #5 ck = ~ck;

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    // Drives one run and measures it; z follows zmask[k] while P_0 is high.
    task automatic do_run(input logic [15:0] mc, input logic s, input logic [16:0] cfg,
                          input logic [31:0] zmask, input int abort_k, input bit start_in_run,
                          output int p0_cnt, output int done_cnt, output bit gap_ok,
                          output bit timeout);
        bit seen_done;
        bit prev_p0;
        p0_cnt = 0; done_cnt = 0; gap_ok = 1'b0; seen_done = 1'b0; prev_p0 = 1'b0;
        max_cyc = mc; soh = s; cfg_c = cfg; start = 1'b1;
        step();
        start = 1'b0; max_cyc = '0; soh = 1'b0; cfg_c = 17'h0;
        for (int c = 0; c < 200; c++) begin
            if (done) begin
                done_cnt++;
                seen_done = 1'b1;
                gap_ok = (prev_p0 || (p0_cnt == 0)) && !p_0;
            end else if (seen_done) begin
                break;
            end
            prev_p0 = p_0;
            if (p_0) begin
                z = zmask[p0_cnt[4:0]];
                abort = (p0_cnt == abort_k);
                p0_cnt++;
            end else begin
                z = 1'b0;
                abort = 1'b0;
            end
            start = start_in_run && p_0;
            max_cyc = start ? 16'd2 : 16'd0;
            cfg_c = start ? 17'h1FFFF : 17'h0;
            step();
        end
        z = 1'b0; abort = 1'b0; start = 1'b0; max_cyc = '0; cfg_c = '0;
        timeout = !seen_done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; max_cyc = 16'd4; cfg_c = 17'h00155;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_busy got=%b want=0", busy); end
        end
        rst = 1'b0; start = 1'b0; max_cyc = '0; cfg_c = '0;
        step();
        total++;
        if ({p_0, busy, done, hit, aborted} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000", {p_0, busy, done, hit, aborted});
        end
        total++;
        if (c_out !== 17'h0) begin bad++; $display("FAIL reset_c_out got=%h want=0", c_out); end
        total++;
        if (hit_cnt !== 16'h0) begin bad++; $display("FAIL reset_hit_cnt got=%0d want=0", hit_cnt); end
`ifdef HIT_TOTAL_EN
        total++;
        if (hit_tot !== 16'h0) begin bad++; $display("FAIL reset_hit_tot got=%0d want=0", hit_tot); end
`endif
    endtask

    task automatic test_basic();
        int p0n, dn; bit gap, to;
        do_run(16'd5, 1'b0, 17'h00021, 32'h0, -1, 1'b0, p0n, dn, gap, to);
        total++;
        if (to) begin bad++; $display("FAIL basic_timeout got=no_done want=done"); end
        total++;
        if (p0n != 5) begin bad++; $display("FAIL basic_p0_len got=%0d want=5", p0n); end
        total++;
        if (dn != 1 || !gap) begin bad++; $display("FAIL basic_done_pulse got=cnt%0d/gap%0b want=cnt1/gap1", dn, gap); end
        total++;
        if (hit !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_hit_busy got=%b%b want=00", hit, busy); end
        total++;
        if (c_out !== 17'h00021) begin bad++; $display("FAIL basic_c_out got=%h want=00021", c_out); end
    endtask

    task automatic test_multi_hit();
        int p0n, dn; bit gap, to;
        do_run(16'd10, 1'b0, 17'h10000, 32'h0000_0088, -1, 1'b0, p0n, dn, gap, to);
        total++;
        if (to || p0n != 10) begin bad++; $display("FAIL multi_p0_len got=%0d want=10", p0n); end
        total++;
        if (hit !== 1'b1 || hit_cnt !== 16'd3) begin bad++; $display("FAIL multi_first_hit got=%b/%0d want=1/3", hit, hit_cnt); end
`ifdef HIT_TOTAL_EN
        total++;
        if (hit_tot !== 16'd2) begin bad++; $display("FAIL multi_hit_tot got=%0d want=2", hit_tot); end
`endif
    endtask

    task automatic test_last_cycle_hit();
        int p0n, dn; bit gap, to;
        do_run(16'd10, 1'b0, 17'h00001, 32'h0000_0200, -1, 1'b0, p0n, dn, gap, to);
        total++;
        if (to || p0n != 10 || hit !== 1'b1 || hit_cnt !== 16'd9) begin
            bad++; $display("FAIL last_hit got=p0 %0d hit %b idx %0d want=p0 10 hit 1 idx 9", p0n, hit, hit_cnt);
        end
    endtask

    task automatic test_stop_on_hit();
        int p0n, dn; bit gap, to;
        do_run(16'd10, 1'b1, 17'h00100, 32'h0000_0010, -1, 1'b0, p0n, dn, gap, to);
        total++;
        if (to || p0n != 5) begin bad++; $display("FAIL soh_p0_len got=%0d want=5", p0n); end
        total++;
        if (dn != 1 || !gap) begin bad++; $display("FAIL soh_done got=cnt%0d/gap%0b want=cnt1/gap1", dn, gap); end
        total++;
        if (hit !== 1'b1 || hit_cnt !== 16'd4) begin bad++; $display("FAIL soh_hit got=%b/%0d want=1/4", hit, hit_cnt); end
`ifdef HIT_TOTAL_EN
        total++;
        if (hit_tot !== 16'd1) begin bad++; $display("FAIL soh_hit_tot got=%0d want=1", hit_tot); end
`endif
    endtask

    task automatic test_zero_len();
        int p0n, dn; bit gap, to;
        do_run(16'd0, 1'b0, 17'h0AAAA, 32'hFFFF_FFFF, -1, 1'b0, p0n, dn, gap, to);
        total++;
        if (to || p0n != 0 || dn != 1 || !gap) begin
            bad++; $display("FAIL zero_len got=p0 %0d done %0d want=p0 0 done 1", p0n, dn);
        end
        total++;
        if (hit !== 1'b0 || c_out !== 17'h0AAAA) begin bad++; $display("FAIL zero_len_state got=%b/%h want=0/0aaaa", hit, c_out); end
    endtask

    task automatic test_start_in_run();
        int p0n, dn; bit gap, to;
        do_run(16'd6, 1'b0, 17'h00808, 32'h0, -1, 1'b1, p0n, dn, gap, to);
        total++;
        if (to || p0n != 6 || dn != 1) begin bad++; $display("FAIL start_in_run_len got=p0 %0d done %0d want=6/1", p0n, dn); end
        total++;
        if (c_out !== 17'h00808) begin bad++; $display("FAIL start_in_run_c_out got=%h want=00808", c_out); end
    endtask

    task automatic test_abort();
        int p0n, dn; bit gap, to;
        do_run(16'd8, 1'b0, 17'h00003, 32'h0000_0004, 2, 1'b0, p0n, dn, gap, to);
        total++;
        if (to || p0n != 3 || aborted !== 1'b1) begin bad++; $display("FAIL abort got=p0 %0d ab %b want=3/1", p0n, aborted); end
        total++;
        if (hit !== 1'b1 || hit_cnt !== 16'd2) begin bad++; $display("FAIL abort_hit got=%b/%0d want=1/2", hit, hit_cnt); end
        do_run(16'd4, 1'b0, 17'h00003, 32'h0, 3, 1'b0, p0n, dn, gap, to);
        total++;
        if (to || p0n != 4 || aborted !== 1'b1 || dn != 1) begin
            bad++; $display("FAIL abort_at_tc got=p0 %0d ab %b done %0d want=4/1/1", p0n, aborted, dn);
        end
        do_run(16'd2, 1'b0, 17'h00003, 32'h0, -1, 1'b0, p0n, dn, gap, to);
        total++;
        if (to || aborted !== 1'b0 || hit !== 1'b0 || hit_cnt !== 16'd0) begin
            bad++; $display("FAIL restart_clears got=ab %b hit %b idx %0d want=0/0/0", aborted, hit, hit_cnt);
        end
    endtask

    task automatic test_rst_mid_run();
        int k; bit reached; bit done_seen;
        int p0n, dn; bit gap, to;
        k = 0; reached = 1'b0; done_seen = 1'b0;
        max_cyc = 16'd20; cfg_c = 17'h01234; start = 1'b1;
        step();
        start = 1'b0; max_cyc = '0; cfg_c = '0;
        for (int c = 0; c < 40; c++) begin
            if (p_0) begin
                if (k == 6) begin reached = 1'b1; break; end
                z = (k == 2);
                k++;
            end
            step();
        end
        z = 1'b0;
        total++;
        if (!reached || hit_cnt !== 16'd2) begin bad++; $display("FAIL rst_mid_reach got=%b/%0d want=1/2", reached, hit_cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({p_0, busy, done, hit, aborted} !== 5'b0 || c_out !== 17'h0 || hit_cnt !== 16'h0) begin
            bad++; $display("FAIL rst_mid_outputs got=%b/%h/%0d want=00000/0/0", {p_0, busy, done, hit, aborted}, c_out, hit_cnt);
        end
        for (int c = 0; c < 25; c++) begin
            if (done || p_0) done_seen = 1'b1;
            step();
        end
        total++;
        if (done_seen) begin bad++; $display("FAIL rst_mid_no_done got=activity want=none"); end
        do_run(16'd3, 1'b0, 17'h00042, 32'h0000_0002, -1, 1'b0, p0n, dn, gap, to);
        total++;
        if (to || p0n != 3 || dn != 1 || hit_cnt !== 16'd1 || c_out !== 17'h00042) begin
            bad++; $display("FAIL rst_mid_restart got=p0 %0d done %0d idx %0d c %h want=3/1/1/00042", p0n, dn, hit_cnt, c_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_hit();
        test_last_cycle_hit();
        test_stop_on_hit();
        test_zero_len();
        test_start_in_run();
        test_abort();
        test_rst_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
